// File: rtl/seq_match_counter_pkg.sv
// Shared defaults and helpers for the sequence match counter.
package seq_match_counter_pkg;

  localparam int unsigned DEF_SYM_W   = 2;
  localparam int unsigned DEF_PAT_LEN = 3;
  localparam int unsigned DEF_CNT_W   = 8;

  // Default pattern 1,2,3 with the oldest symbol in the low bits.
  localparam logic [DEF_PAT_LEN*DEF_SYM_W-1:0] DEF_PAT_BITS = 6'b11_10_01;

  // Low bit index of symbol idx within a packed window.
  function automatic int unsigned sym_lo(input int unsigned idx, input int unsigned sym_w);
    return idx * sym_w;
  endfunction

endpackage

// File: rtl/seq_match_counter_window.sv
// Shift window holding the last PAT_LEN accepted symbols plus a saturating fill count.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   clear          empty the window and zero the fill count
//   shift          accept sym into the window
//   sym            incoming symbol
//   next_window_c  window including sym, oldest symbol in the low bits
//   next_fill_c    fill count including sym, saturating at PAT_LEN
module seq_match_counter_window
  import seq_match_counter_pkg::*;
#(
  parameter int unsigned SYM_W   = DEF_SYM_W,
  parameter int unsigned PAT_LEN = DEF_PAT_LEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          shift,
  input  logic [SYM_W-1:0]              sym,
  output logic [PAT_LEN*SYM_W-1:0]      next_window_c,
  output logic [$clog2(PAT_LEN+1)-1:0]  next_fill_c
);

  localparam int unsigned WIN_W  = PAT_LEN * SYM_W;
  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

  logic [WIN_W-1:0]  window;
  logic [FILL_W-1:0] fill;

  // New symbol enters at the top slot; the oldest drops out of the bottom.
  generate
    if (PAT_LEN == 1) begin : g_single
      assign next_window_c = sym;
    end else begin : g_multi
      assign next_window_c = {sym, window[WIN_W-1:sym_lo(1, SYM_W)]};
    end
  endgenerate

  assign next_fill_c = (fill == FILL_W'(PAT_LEN)) ? fill : fill + FILL_W'(1);

  // Window and fill registers.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      window <= '0;
      fill   <= '0;
    end else if (shift) begin
      window <= next_window_c;
      fill   <= next_fill_c;
    end
  end

endmodule

// File: rtl/seq_match_counter.sv
// Detects a loadable PAT_LEN-symbol pattern in a symbol stream and counts matches.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   in_valid    sym is sampled this cycle
//   sym         input symbol
//   pat_load    load pat_data as the pattern and clear history
//   pat_data    pattern, pat[0] (oldest) in the low bits
//   cnt_clr     clear the match counter
//   hit         one-cycle pulse after the final symbol of a match
//   count       saturating match count
//   count_sat   count is at its maximum
module seq_match_counter
  import seq_match_counter_pkg::*;
#(
  parameter int unsigned                  SYM_W   = DEF_SYM_W,
  parameter int unsigned                  PAT_LEN = DEF_PAT_LEN,
  parameter int unsigned                  CNT_W   = DEF_CNT_W,
  parameter int unsigned                  OVERLAP = 1,
  parameter logic [PAT_LEN*SYM_W-1:0]     DEF_PAT = (PAT_LEN*SYM_W)'(DEF_PAT_BITS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [SYM_W-1:0]          sym,
  input  logic                      pat_load,
  input  logic [PAT_LEN*SYM_W-1:0]  pat_data,
  input  logic                      cnt_clr,
  output logic                      hit,
  output logic [CNT_W-1:0]          count,
  output logic                      count_sat
);

  localparam int unsigned      WIN_W   = PAT_LEN * SYM_W;
  localparam int unsigned      FILL_W  = $clog2(PAT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIN_W-1:0]  pat;
  logic [WIN_W-1:0]  next_window_c;
  logic [FILL_W-1:0] next_fill_c;
  logic              accept_c;
  logic              match_c;
  logic              win_clear_c;
  logic [CNT_W-1:0]  count_next_c;

  // A symbol arriving with pat_load is dropped.
  assign accept_c = in_valid & ~pat_load;

  assign match_c = accept_c
                 && (next_fill_c == FILL_W'(PAT_LEN))
                 && (next_window_c == pat);

  // Non-overlapping mode restarts the history after every hit.
  assign win_clear_c = pat_load | (match_c & (OVERLAP == 0));

  seq_match_counter_window #(
    .SYM_W   (SYM_W),
    .PAT_LEN (PAT_LEN)
  ) u_window (
    .clk           (clk),
    .reset         (reset),
    .clear         (win_clear_c),
    .shift         (accept_c),
    .sym           (sym),
    .next_window_c (next_window_c),
    .next_fill_c   (next_fill_c)
  );

  // Saturating counter; clear wins over an increment.
  always_comb begin
    count_next_c = count;
    if (cnt_clr) begin
      count_next_c = '0;
    end else if (match_c && (count != CNT_MAX)) begin
      count_next_c = count + CNT_W'(1);
    end
  end

  // Pattern, hit and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat       <= DEF_PAT;
      hit       <= 1'b0;
      count     <= '0;
      count_sat <= 1'b0;
    end else begin
      if (pat_load) begin
        pat <= pat_data;
      end
      hit       <= match_c;
      count     <= count_next_c;
      count_sat <= (count_next_c == CNT_MAX);
    end
  end

endmodule
